// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Iteration counter only ever holds DATA_WIDTH-1 down to 0.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/carry_look_ahead_adder.sv
// Parameterised carry-lookahead adder; each carry is the flat generate/propagate sum of products.
module carry_look_ahead_adder #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] sum_out,
    output logic                  carry_out
);

    logic [DATA_WIDTH-1:0] gen;
    logic [DATA_WIDTH-1:0] prop;
    logic [DATA_WIDTH:0]   carry;
    logic                  prod;

    assign gen  = a_in & b_in;
    assign prop = a_in ^ b_in;

    always_comb begin
        carry    = '0;
        prod     = 1'b0;
        carry[0] = carry_in;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            // carry_in propagated through every stage up to i
            prod = carry_in;
            for (int j = 0; j <= i; j++) begin
                prod = prod & prop[j];
            end
            carry[i+1] = prod;
            for (int j = 0; j <= i; j++) begin
                prod = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & prop[k];
                end
                carry[i+1] = carry[i+1] | prod;
            end
        end
    end

    assign sum_out   = prop ^ carry[DATA_WIDTH-1:0];
    assign carry_out = carry[DATA_WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with valid/ready
// request and result ports. Trial subtracts run on the carry-lookahead adder.
//
// state | meaning
// IDLE  | ready for a request; outputs hold the last result
// CALC  | shift/subtract iterations, DATA_WIDTH cycles
// DONE  | publish result, hold it until the consumer accepts
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic [DATA_WIDTH-1:0] dividend_in,
    input  logic [DATA_WIDTH-1:0] divisor_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [DATA_WIDTH-1:0] quotient_out,
    output logic [DATA_WIDTH-1:0] remainder_out,
    output logic                  div_by_zero_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_width(DATA_WIDTH);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dsr_q, dsr_d;
    logic          dbz_q, dbz_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  quo_out_q, quo_out_d;
    logic [W-1:0]  rem_out_q, rem_out_d;
    logic          dbz_out_q, dbz_out_d;

    logic [W:0]    rem_shift;
    logic [W:0]    trial;
    logic          no_borrow;
    logic          unused_trial_msb;

    assign rem_shift = {rem_q, quo_q[W-1]};

    carry_look_ahead_adder #(.DATA_WIDTH(W + 1)) u_trial_sub (
        .a_in      (rem_shift),
        .b_in      (~{1'b0, dsr_q}),
        .carry_in  (1'b1),
        .sum_out   (trial),
        .carry_out (no_borrow)
    );

    // An accepted trial is always below the divisor, so its top bit is zero.
    assign unused_trial_msb = trial[W];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        quo_out_d   = quo_out_q;
        rem_out_d   = rem_out_q;
        dbz_out_d   = dbz_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid_in) begin
                    dsr_d = divisor_in;
                    cnt_d = CW'(W - 1);
                    if (divisor_in == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend_in;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        quo_d   = dividend_in;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                rem_d = no_borrow ? trial[W-1:0] : rem_shift[W-1:0];
                quo_d = {quo_q[W-2:0], no_borrow};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                // First DONE cycle registers the result; it is then held until taken.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    quo_out_d   = quo_q;
                    rem_out_d   = rem_q;
                    dbz_out_d   = dbz_q;
                end else if (out_ready_in) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            quo_out_q   <= '0;
            rem_out_q   <= '0;
            dbz_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            quo_out_q   <= quo_out_d;
            rem_out_q   <= rem_out_d;
            dbz_out_q   <= dbz_out_d;
        end
    end

    assign in_ready_out    = (state_q == IDLE);
    assign out_valid_out   = out_valid_q;
    assign quotient_out    = quo_out_q;
    assign remainder_out   = rem_out_q;
    assign div_by_zero_out = dbz_out_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of seq_restoring_divider with DATA_WIDTH=4, scoreboard-based.
module tb_seq_restoring_divider;

    localparam int DW = 4;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          in_valid_in;
    logic          in_ready_out;
    logic [DW-1:0] dividend_in;
    logic [DW-1:0] divisor_in;
    logic          out_valid_out;
    logic          out_ready_in;
    logic [DW-1:0] quotient_out;
    logic [DW-1:0] remainder_out;
    logic          div_by_zero_out;

    typedef struct {
        logic [DW-1:0] n;
        logic [DW-1:0] d;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          z;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk_in = ~clk_in;

    seq_restoring_divider #(.DATA_WIDTH(DW)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .in_valid_in     (in_valid_in),
        .in_ready_out    (in_ready_out),
        .dividend_in     (dividend_in),
        .divisor_in      (divisor_in),
        .out_valid_out   (out_valid_out),
        .out_ready_in    (out_ready_in),
        .quotient_out    (quotient_out),
        .remainder_out   (remainder_out),
        .div_by_zero_out (div_by_zero_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic send(input logic [DW-1:0] n, input logic [DW-1:0] d);
        exp_t e;
        int   waits = 0;
        while (!in_ready_out && waits < 20) begin
            @(negedge clk_in);
            waits++;
        end
        if (!in_ready_out) check("send_ready_timeout", 32'(in_ready_out), 32'd1);
        in_valid_in = 1'b1;
        dividend_in = n;
        divisor_in  = d;
        @(posedge clk_in);
        e.n = n;
        e.d = d;
        e.z = (d == 0);
        e.q = (d == 0) ? {DW{1'b1}} : DW'(n / d);
        e.r = (d == 0) ? n : DW'(n % d);
        sb.push_back(e);
        @(negedge clk_in);
        in_valid_in = 1'b0;
    endtask

    // out_valid_out must be low after edges t..t+lat-1 and high after edge t+lat.
    task automatic wait_valid(input string tag, input int lat);
        logic early = 1'b0;
        for (int k = 0; k < lat; k++) begin
            if (out_valid_out) early = 1'b1;
            @(negedge clk_in);
        end
        check({tag, "_early"}, 32'(early), 32'd0);
        check({tag, "_valid"}, 32'(out_valid_out), 32'd1);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"}, 32'(quotient_out), 32'(e.q));
            check({tag, "_r"}, 32'(remainder_out), 32'(e.r));
            check({tag, "_z"}, 32'(div_by_zero_out), 32'(e.z));
            if (e.d != 0) begin
                check({tag, "_identity"}, 32'(quotient_out) * 32'(e.d) + 32'(remainder_out), 32'(e.n));
                check({tag, "_r_lt_d"}, 32'(remainder_out < e.d), 32'd1);
            end
        end
    endtask

    task automatic drain(input string tag);
        out_ready_in = 1'b1;
        @(negedge clk_in);
        check({tag, "_idle_ready"}, 32'(in_ready_out), 32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid_out), 32'd0);
        out_ready_in = 1'b0;
    endtask

    initial begin
        logic seen;
        logic got;
        rst_n_in     = 1'b0;
        in_valid_in  = 1'b0;
        dividend_in  = '0;
        divisor_in   = '0;
        out_ready_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_in_ready", 32'(in_ready_out), 32'd1);
        check("rst_out_valid", 32'(out_valid_out), 32'd0);
        check("rst_q", 32'(quotient_out), 32'd0);
        check("rst_r", 32'(remainder_out), 32'd0);
        check("rst_z", 32'(div_by_zero_out), 32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        send(4'hF, 4'h4);
        wait_valid("f_div_4", 5);
        check_result("f_div_4");
        check("f_div_4_q_const", 32'(quotient_out), 32'd3);
        check("f_div_4_r_const", 32'(remainder_out), 32'd3);
        drain("f_div_4");

        send(4'h0, 4'h5);
        wait_valid("0_div_5", 5);
        check_result("0_div_5");
        drain("0_div_5");

        send(4'hF, 4'h1);
        wait_valid("f_div_1", 5);
        check_result("f_div_1");
        check("f_div_1_q_const", 32'(quotient_out), 32'hF);
        drain("f_div_1");

        send(4'h7, 4'h0);
        wait_valid("7_div_0", 1);
        check_result("7_div_0");
        check("7_div_0_z_const", 32'(div_by_zero_out), 32'd1);
        drain("7_div_0");

        send(4'hD, 4'h3);
        wait_valid("d_div_3", 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            check("bp_hold", {in_ready_out, out_valid_out, 2'b00, quotient_out, remainder_out},
                  {1'b0, 1'b1, 2'b00, 4'h4, 4'h1});
        end
        check_result("d_div_3");
        drain("d_div_3");

        send(4'hB, 4'h2);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        check("abort_in_ready", 32'(in_ready_out), 32'd1);
        check("abort_out_valid", 32'(out_valid_out), 32'd0);
        check("abort_q", 32'(quotient_out), 32'd0);
        check("abort_r", 32'(remainder_out), 32'd0);
        rst_n_in = 1'b1;
        void'(sb.pop_back());
        out_ready_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (out_valid_out) seen = 1'b1;
        end
        check("abort_no_stale", 32'(seen), 32'd0);
        out_ready_in = 1'b0;

        for (int n = 0; n < 16; n++) begin
            for (int d = 0; d < 16; d++) begin
                send(DW'(n), DW'(d));
                got = 1'b0;
                for (int c = 0; c < 60 && !got; c++) begin
                    @(negedge clk_in);
                    if (out_valid_out) begin
                        out_ready_in = 1'($urandom_range(0, 1));
                        if (out_ready_in) begin
                            check_result("sweep");
                            got = 1'b1;
                        end
                    end
                end
                if (!got) begin
                    check("sweep_timeout", 32'(out_valid_out), 32'd1);
                    void'(sb.pop_front());
                end
                @(negedge clk_in);
                out_ready_in = 1'b0;
            end
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
